stream_demux12: RTL and testbench
=================================

Name: stream_demux12

Overview:
- 1-to-2 valid/ready stream demultiplexer for the MIPS datapath; it is the distributing counterpart of the 2:1 select mux.
- It accepts one 32-bit word per handshake and steers it, by a select bit, into one of two independent output channels.
- Each output channel has its own small FIFO, so a stalled sink on one channel does not block words already queued for the other.
- Typical use: splitting memory read responses between the instruction-fetch and load/store paths.

Parameters:
- WIDTH, 32: data width in bits.
- DEPTH, 2: entries per output FIFO; must be a power of 2 and at least 2.
- CNT_W, 16: width of the statistics counters (used only with the optional feature).

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  demux can accept the input word.
- in_data  in  WIDTH  input word.
- in_sel  in  1  destination select: 0 routes to channel 0, 1 routes to channel 1.
- out0_valid  out  1  channel 0 head entry valid.
- out0_ready  in  1  channel 0 sink accepts the head entry.
- out0_data  out  WIDTH  channel 0 head data.
- out1_valid  out  1  channel 1 head entry valid.
- out1_ready  in  1  channel 1 sink accepts the head entry.
- out1_data  out  WIDTH  channel 1 head data.
- cnt0  out  CNT_W  words accepted for channel 0 (only with DEMUX_STATS_EN).
- cnt1  out  CNT_W  words accepted for channel 1 (only with DEMUX_STATS_EN).

Behaviour:
- Clock and reset: one clock domain; reset is asynchronous and active-low.
- Reset values:
  - both FIFOs empty, with read/write pointers and occupancy counts at 0.
  - out0_valid = 0, out1_valid = 0.
  - out0_data and out1_data = 0.
  - cnt0 and cnt1 = 0.
- Reset asserted mid-operation discards every queued word immediately; no output handshake completes during reset.
- in_ready = NOT full(chan[in_sel]).
  - The ready path is combinational from in_sel plus registered full flags only; no combinational path from out*_ready to in_ready.
  - in_sel and in_data must stay stable while in_valid=1 and in_ready=0. The bench flags a violation.
- Accept event: in_valid AND in_ready pushes in_data into FIFO[in_sel] on the clock edge.
- Latency: an accepted word is visible at outN_valid/outN_data on the next cycle. There is no bypass, even when the FIFO is empty.
- Output event: outN_valid AND outN_ready pops the head entry of channel N. Channels 0 and 1 pop independently, in the same cycle if both handshake.
- Ordering: FIFO order is preserved within each channel. There is no ordering guarantee between channels.
- Full: when a FIFO is full, a simultaneous pop does NOT permit a push that cycle, because in_ready is derived from the registered full flag. The push happens the following cycle.
- Empty: when the FIFO is empty, outN_valid = 0 and outN_data holds its last popped value.
- Simultaneous push and pop on a non-full, non-empty channel: occupancy is unchanged and both pointers advance.
- Pointer arithmetic: pointers are log2(DEPTH) bits and wrap from DEPTH-1 to 0. Occupancy is log2(DEPTH)+1 bits.
- outN_valid and outN_data are driven from FIFO storage and occupancy, not from in_*.

Optional Feature:
- Macro: DEMUX_STATS_EN.
- Defined:
  - cnt0 and cnt1 ports exist.
  - Each counter increments by 1 on every accept event to its channel.
  - Counters wrap from 2^CNT_W-1 to 0.
  - Counters reset to 0.
- Undefined: the cnt0/cnt1 ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Shared package/include demux_defs:
  - CH0 = 1'b0, CH1 = 1'b1.
  - the default WIDTH/DEPTH constants.
- One natural sub-module: demux_fifo, a synchronous FIFO of parameterised WIDTH/DEPTH with push, pop, full, empty, head data and the same clk/reset_n. It is instantiated twice, and the top level holds only the steering and counter logic.

Test Plan:
- Reset → all outputs 0. Then push 0x0000_0001 with in_sel=0 → next cycle out0_valid=1, out0_data=0x0000_0001, out1_valid=0.
- Alternate in_sel 0/1 for words 0xA0..0xA3 with both sinks ready → channel 0 yields 0xA0, 0xA2 and channel 1 yields 0xA1, 0xA3, each in order, each word one cycle after its accept.
- Hold out0_ready=0 and push 0x10, 0x11 to channel 0 → after two accepts in_ready=0 while in_sel=0. Then switch in_sel=1 and push 0x20 → accepted, and out1_data=0x20.
- Channel 0 full (DEPTH=2) with out0_ready=1 and in_valid=1, in_sel=0 → pop occurs, no push that cycle, push accepted the next cycle; no word is lost or duplicated.
- Assert reset_n=0 with 1 word queued in each channel → out0_valid and out1_valid drop to 0 immediately (asynchronously), and remain 0 after release until new accepts.
- With DEMUX_STATS_EN and CNT_W=4: 17 accepts to channel 1 → cnt1=1 (wrapped) and cnt0=0. Rebuild without the macro → the ports are absent and the other tests still pass.

Source files
------------

// File: rtl/stream_demux12_pkg.sv
// Shared definitions for the stream_demux12 block: channel select encodings
// and default sizing constants.
// The optional statistics counters are enabled with the DEMUX_STATS_EN macro.
package demux_defs;

    // Values of in_sel
    localparam logic CH0 = 1'b0;
    localparam logic CH1 = 1'b1;

    // Default sizing
    localparam int unsigned DEF_WIDTH = 32;
    localparam int unsigned DEF_DEPTH = 2;
    localparam int unsigned DEF_CNT_W = 16;

    // Pointer width for a FIFO of the given depth (at least one bit).
    function automatic int unsigned ptr_width(int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/stream_demux12_if.sv
// Valid/ready bundle for stream_demux12: one input stream with a select bit
// and two output streams. The master side is the producer/sink environment,
// the slave side is the demux itself.
// The optional statistics counters (DEMUX_STATS_EN) are plain top-level ports.
interface stream_demux12_if
    import demux_defs::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_sel;

    logic             out0_valid;
    logic             out0_ready;
    logic [WIDTH-1:0] out0_data;

    logic             out1_valid;
    logic             out1_ready;
    logic [WIDTH-1:0] out1_data;

    modport master (
        output in_valid, in_data, in_sel, out0_ready, out1_ready,
        input  in_ready, out0_valid, out0_data, out1_valid, out1_data
    );

    modport slave (
        input  in_valid, in_data, in_sel, out0_ready, out1_ready,
        output in_ready, out0_valid, out0_data, out1_valid, out1_data
    );

endinterface

// File: rtl/stream_demux12_fifo.sv
// demux_fifo: small synchronous FIFO used for each demux output channel.
// The full flag is registered so the demux ready path never depends on pop.
// When empty, head_data keeps showing the last popped word.
// Used by stream_demux12 (statistics option: DEMUX_STATS_EN, not used here).
module demux_fifo
    import demux_defs::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned DEPTH = DEF_DEPTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head_data
);

    localparam int unsigned PW = ptr_width(DEPTH);

    typedef logic [PW-1:0] ptr_t;
    typedef logic [PW:0]   cnt_t;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] last_q;
    ptr_t             wr_ptr_q, rd_ptr_q;
    cnt_t             count_q, count_d;
    logic             full_q, full_d;
    logic             do_push, do_pop;

    // Guard the handshakes against the registered state.
    assign do_push = push && !full_q;
    assign do_pop  = pop && (count_q != '0);

    // Occupancy next-state: simultaneous push and pop leave it unchanged.
    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + cnt_t'(1);
            2'b01:   count_d = count_q - cnt_t'(1);
            default: count_d = count_q;
        endcase
        full_d = (count_d == cnt_t'(DEPTH));
    end

    // Pointers, occupancy and full flag; pointers wrap naturally (DEPTH is 2^n).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + ptr_t'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + ptr_t'(1);
            end
            count_q <= count_d;
            full_q  <= full_d;
        end
    end

    // Storage plus a copy of the most recently popped word.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            last_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data;
            end
            if (do_pop) begin
                last_q <= mem_q[rd_ptr_q];
            end
        end
    end

    assign full      = full_q;
    assign empty     = (count_q == '0);
    assign head_data = empty ? last_q : mem_q[rd_ptr_q];

endmodule

// File: rtl/stream_demux12.sv
// stream_demux12: 1-to-2 valid/ready demultiplexer. Each accepted word is
// steered by in_sel into one of two independent output FIFOs, so a stalled
// sink on one channel never blocks the other.
// Optional per-channel accept counters are built when DEMUX_STATS_EN is defined.
module stream_demux12
    import demux_defs::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned DEPTH = DEF_DEPTH,
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset_n,
    stream_demux12_if.slave  bus
`ifdef DEMUX_STATS_EN
    ,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
`endif
);

    logic full0, full1;
    logic empty0, empty1;
    logic ready_w, accept;
    logic push0, push1;
    logic pop0, pop1;

    // Ready depends only on in_sel and the registered full flags.
    assign ready_w     = (bus.in_sel == CH1) ? !full1 : !full0;
    assign bus.in_ready = ready_w;
    assign accept      = bus.in_valid && ready_w;
    assign push0       = accept && (bus.in_sel == CH0);
    assign push1       = accept && (bus.in_sel == CH1);

    assign bus.out0_valid = !empty0;
    assign bus.out1_valid = !empty1;
    assign pop0           = !empty0 && bus.out0_ready;
    assign pop1           = !empty1 && bus.out1_ready;

    demux_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo0 (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push0),
        .push_data (bus.in_data),
        .pop       (pop0),
        .full      (full0),
        .empty     (empty0),
        .head_data (bus.out0_data)
    );

    demux_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo1 (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push1),
        .push_data (bus.in_data),
        .pop       (pop1),
        .full      (full1),
        .empty     (empty1),
        .head_data (bus.out1_data)
    );

`ifdef DEMUX_STATS_EN
    logic [CNT_W-1:0] cnt0_q, cnt1_q;

    // Accept counters, one per channel, wrapping at 2^CNT_W.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            if (push0) begin
                cnt0_q <= cnt0_q + CNT_W'(1);
            end
            if (push1) begin
                cnt1_q <= cnt1_q + CNT_W'(1);
            end
        end
    end

    assign cnt0 = cnt0_q;
    assign cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_stream_demux12.sv
// Self-checking bench for stream_demux12: directed steps followed by random
// traffic, all checked against a queue-based reference model.
// Builds with or without DEMUX_STATS_EN.
module tb_stream_demux12;
    import demux_defs::*;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned DEPTH = 2;
    localparam int unsigned CNT_W = 4;

    logic clk = 1'b0;
    logic reset_n;

    always #5 clk = ~clk;

    stream_demux12_if #(.WIDTH(WIDTH)) bus ();

`ifdef DEMUX_STATS_EN
    logic [CNT_W-1:0] cnt0, cnt1;
`endif

    stream_demux12 #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
`ifdef DEMUX_STATS_EN
        ,
        .cnt0    (cnt0),
        .cnt1    (cnt1)
`endif
    );

    // Reference model: one queue per channel plus last popped word and accept counts.
    logic [WIDTH-1:0] q0[$];
    logic [WIDTH-1:0] q1[$];
    logic [WIDTH-1:0] last0, last1;
    int unsigned      acc0, acc1;

    int checks;
    int errors;

    bit               prev_stall;
    logic             prev_sel;
    logic [WIDTH-1:0] prev_data;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        check("out0_valid", {63'd0, bus.out0_valid}, {63'd0, q0.size() != 0});
        check("out0_data", {32'd0, bus.out0_data}, {32'd0, (q0.size() != 0) ? q0[0] : last0});
        check("out1_valid", {63'd0, bus.out1_valid}, {63'd0, q1.size() != 0});
        check("out1_data", {32'd0, bus.out1_data}, {32'd0, (q1.size() != 0) ? q1[0] : last1});
`ifdef DEMUX_STATS_EN
        check("cnt0", {60'd0, cnt0}, 64'(acc0 % (1 << CNT_W)));
        check("cnt1", {60'd0, cnt1}, 64'(acc1 % (1 << CNT_W)));
`endif
    endtask

    // One clock cycle: called at a falling edge, returns at the next falling edge.
    task automatic cycle(input bit v, input logic sel, input logic [WIDTH-1:0] d,
                         input bit r0, input bit r1);
        bit exp_ready, acc, p0, p1;
        if (prev_stall && v && (sel !== prev_sel || d !== prev_data)) begin
            errors++;
            $error("FAIL protocol: in_sel/in_data changed while stalled");
        end
        bus.in_valid   = v;
        bus.in_sel     = sel;
        bus.in_data    = d;
        bus.out0_ready = r0;
        bus.out1_ready = r1;
        #1;
        exp_ready = sel ? (q1.size() < DEPTH) : (q0.size() < DEPTH);
        check("in_ready", {63'd0, bus.in_ready}, {63'd0, exp_ready});
        acc = v && exp_ready;
        p0  = r0 && (q0.size() != 0);
        p1  = r1 && (q1.size() != 0);
        prev_stall = v && !exp_ready;
        prev_sel   = sel;
        prev_data  = d;
        @(posedge clk);
        #1;
        if (p0) last0 = q0.pop_front();
        if (p1) last1 = q1.pop_front();
        if (acc) begin
            if (sel) begin
                q1.push_back(d);
                acc1++;
            end else begin
                q0.push_back(d);
                acc0++;
            end
        end
        @(negedge clk);
        check_outputs();
    endtask

    // Asynchronous reset mid-cycle; called at a falling edge.
    task automatic do_reset();
        #2;
        reset_n = 1'b0;
        #1;
        check("rst out0_valid", {63'd0, bus.out0_valid}, 64'd0);
        check("rst out1_valid", {63'd0, bus.out1_valid}, 64'd0);
        q0.delete();
        q1.delete();
        last0 = '0;
        last1 = '0;
        acc0 = 0;
        acc1 = 0;
        prev_stall = 1'b0;
        bus.in_valid   = 1'b0;
        bus.in_sel     = 1'b0;
        bus.in_data    = '0;
        bus.out0_ready = 1'b0;
        bus.out1_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        check_outputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bit               v, r0, r1;
        logic             sel;
        logic [WIDTH-1:0] d;

        checks = 0;
        errors = 0;
        reset_n = 1'b1;
        bus.in_valid   = 1'b0;
        bus.in_sel     = 1'b0;
        bus.in_data    = '0;
        bus.out0_ready = 1'b0;
        bus.out1_ready = 1'b0;
        #1;
        do_reset();

        // Reset state, then a single word to channel 0.
        check("reset out0_data", {32'd0, bus.out0_data}, 64'd0);
        check("reset out1_data", {32'd0, bus.out1_data}, 64'd0);
        cycle(1'b1, CH0, 32'h0000_0001, 1'b0, 1'b0);
        check("first valid", {63'd0, bus.out0_valid}, 64'd1);
        check("first data", {32'd0, bus.out0_data}, 64'h1);
        check("first other", {63'd0, bus.out1_valid}, 64'd0);
        cycle(1'b0, CH0, '0, 1'b1, 1'b1);

        // Alternate channels with both sinks ready.
        for (int i = 0; i < 4; i++) begin
            sel = i[0];
            cycle(1'b1, sel, 32'hA0 + 32'(i), 1'b1, 1'b1);
            if (sel)
                check("alt ch1 word", {32'd0, bus.out1_data}, 64'hA0 + 64'(i));
            else
                check("alt ch0 word", {32'd0, bus.out0_data}, 64'hA0 + 64'(i));
        end
        cycle(1'b0, CH0, '0, 1'b1, 1'b1);

        // Fill channel 0 with its sink stalled; channel 1 stays open.
        cycle(1'b1, CH0, 32'h10, 1'b0, 1'b1);
        cycle(1'b1, CH0, 32'h11, 1'b0, 1'b1);
        cycle(1'b1, CH0, 32'h12, 1'b0, 1'b1);
        check("ch0 held full", {63'd0, bus.out0_valid}, 64'd1);
        cycle(1'b0, CH0, '0, 1'b0, 1'b1);
        cycle(1'b1, CH1, 32'h20, 1'b0, 1'b1);
        check("ch1 bypasses stall", {32'd0, bus.out1_data}, 64'h20);

        // Full channel with pop: no push this cycle, push lands next cycle.
        cycle(1'b1, CH0, 32'h12, 1'b1, 1'b1);
        check("full pop head", {32'd0, bus.out0_data}, 64'h11);
        cycle(1'b1, CH0, 32'h12, 1'b1, 1'b1);
        check("push after full", {32'd0, bus.out0_data}, 64'h12);
        cycle(1'b0, CH0, '0, 1'b1, 1'b1);
        check("drained hold", {32'd0, bus.out0_data}, 64'h12);

        // Reset with one word queued per channel.
        cycle(1'b1, CH0, 32'h30, 1'b0, 1'b0);
        cycle(1'b1, CH1, 32'h31, 1'b0, 1'b0);
        do_reset();
        cycle(1'b0, CH0, '0, 1'b1, 1'b1);
        check("post reset valid0", {63'd0, bus.out0_valid}, 64'd0);
        check("post reset valid1", {63'd0, bus.out1_valid}, 64'd0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            if (prev_stall) begin
                v   = 1'b1;
                sel = prev_sel;
                d   = prev_data;
            end else begin
                v   = ($urandom_range(0, 3) != 0);
                sel = $urandom_range(0, 1) != 0;
                d   = $urandom;
            end
            r0 = ($urandom_range(0, 2) != 0);
            r1 = ($urandom_range(0, 3) == 0);
            cycle(v, sel, d, r0, r1);
        end

`ifdef DEMUX_STATS_EN
        // Counter wrap: 17 accepts to channel 1.
        do_reset();
        for (int i = 0; i < 17; i++) begin
            cycle(1'b1, CH1, 32'(i), 1'b1, 1'b1);
        end
        check("cnt1 wrapped", {60'd0, cnt1}, 64'd1);
        check("cnt0 idle", {60'd0, cnt0}, 64'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
